// File: rtl/line_raster.sv
// rtl/line_raster.sv - Bresenham line rasteriser writing pixels into an SRAM framebuffer.
// Each pixel takes one PLOT (address setup, waits for grant) and one WRITE (we_n low) cycle.
module line_raster #(
   parameter int CW        = 10,
   parameter int H_RES     = 640,
   parameter int V_RES     = 480,
   parameter int AW        = 20,
   parameter int DW        = 16,
   parameter int BASE_ADDR = 0
) (
   input  logic          clk50,
   input  logic          rst,
   input  logic [CW-1:0] x0,
   input  logic [CW-1:0] y0,
   input  logic [CW-1:0] x1,
   input  logic [CW-1:0] y1,
   input  logic [DW-1:0] color,
   input  logic          start,
   input  logic          abort,
   input  logic          grant,
   output logic          busy,
   output logic          done,
   output logic [CW:0]   pix_cnt,
   output logic [AW-1:0] sram_addr,
   output logic [DW-1:0] sram_dq,
   output logic          sram_ce_n,
   output logic          sram_oe_n,
   output logic          sram_we_n,
   output logic          sram_ub_n,
   output logic          sram_lb_n
);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PLOT, S_WRITE, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       x_q, x_d, y_q, y_d, x1_q, x1_d, y1_q, y1_d;
   logic [DW-1:0]       color_q, color_d, dq_q, dq_d;
   logic signed [CW:0]  dx_q, dx_d, dy_q, dy_d;
   logic signed [CW+1:0] err_q, err_d;
   logic                sxn_q, sxn_d, syn_q, syn_d;
   logic [AW-1:0]       addr_q, addr_d;
   logic                we_n_q, we_n_d;
   logic [CW:0]         pix_q, pix_d;

   logic [CW-1:0]       abs_x, abs_y;
   logic [31:0]         lin;
   logic                in_range, at_end, drive;
   logic signed [CW+2:0] e2, dx_e, dy_e;

   always_ff @(posedge clk50 or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         x1_q    <= '0;
         y1_q    <= '0;
         color_q <= '0;
         dq_q    <= '0;
         dx_q    <= '0;
         dy_q    <= '0;
         err_q   <= '0;
         sxn_q   <= 1'b0;
         syn_q   <= 1'b0;
         addr_q  <= '0;
         we_n_q  <= 1'b1;
         pix_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         x1_q    <= x1_d;
         y1_q    <= y1_d;
         color_q <= color_d;
         dq_q    <= dq_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         err_q   <= err_d;
         sxn_q   <= sxn_d;
         syn_q   <= syn_d;
         addr_q  <= addr_d;
         we_n_q  <= we_n_d;
         pix_q   <= pix_d;
      end
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      x1_d    = x1_q;
      y1_d    = y1_q;
      color_d = color_q;
      dq_d    = dq_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      err_d   = err_q;
      sxn_d   = sxn_q;
      syn_d   = syn_q;
      addr_d  = addr_q;
      we_n_d  = 1'b1;
      pix_d   = pix_q;

      abs_x    = (x1_q >= x_q) ? (x1_q - x_q) : (x_q - x1_q);
      abs_y    = (y1_q >= y_q) ? (y1_q - y_q) : (y_q - y1_q);
      lin      = 32'(BASE_ADDR) + 32'(y_q) * 32'(H_RES) + 32'(x_q);
      in_range = (32'(x_q) < 32'(H_RES)) && (32'(y_q) < 32'(V_RES));
      at_end   = (x_q == x1_q) && (y_q == y1_q);
      e2       = {err_q[CW+1], err_q, 1'b0};
      dx_e     = (CW+3)'(dx_q);
      dy_e     = (CW+3)'(dy_q);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               x_d     = x0;
               y_d     = y0;
               x1_d    = x1;
               y1_d    = y1;
               color_d = color;
               pix_d   = '0;
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            dx_d    = signed'({1'b0, abs_x});
            dy_d    = -signed'({1'b0, abs_y});
            err_d   = (CW+2)'(signed'({1'b0, abs_x})) - (CW+2)'(signed'({1'b0, abs_y}));
            sxn_d   = x1_q < x_q;
            syn_d   = y1_q < y_q;
            state_d = S_PLOT;
         end
         S_PLOT: begin
            if (grant) begin
               addr_d  = AW'(lin);
               dq_d    = color_q;
               we_n_d  = !in_range;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            if (!we_n_q) pix_d = pix_q + 1'b1;
            if (at_end) begin
               state_d = S_DONE;
            end else begin
               // Both tests use the pre-step e2, so a diagonal step applies both.
               if (e2 >= dy_e) begin
                  err_d = err_d + (CW+2)'(dy_q);
                  x_d   = sxn_q ? x_q - 1'b1 : x_q + 1'b1;
               end
               if (e2 <= dx_e) begin
                  err_d = err_d + (CW+2)'(dx_q);
                  y_d   = syn_q ? y_q - 1'b1 : y_q + 1'b1;
               end
               state_d = S_PLOT;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (abort && state_q != S_IDLE) begin
         state_d = S_IDLE;
         we_n_d  = 1'b1;
      end
   end

   assign busy    = state_q != S_IDLE;
   assign done    = state_q == S_DONE;
   assign pix_cnt = pix_q;

   // The bus stays ours through WRITE even if the arbiter has moved on.
   assign drive     = grant || (state_q == S_WRITE);
   assign sram_addr = drive ? addr_q : {AW{1'bz}};
   assign sram_dq   = drive ? dq_q : {DW{1'bz}};
   assign sram_ce_n = drive ? 1'b0 : 1'bz;
   assign sram_oe_n = drive ? 1'b1 : 1'bz;
   assign sram_we_n = drive ? we_n_q : 1'bz;
   assign sram_ub_n = drive ? 1'b0 : 1'bz;
   assign sram_lb_n = drive ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_line_raster.sv
// tb/tb_line_raster.sv - scoreboard bench for line_raster: expected SRAM writes queued by stimulus, popped by a monitor.
module tb_line_raster;

   logic        clk50 = 1'b0;
   logic        rst;
   logic [9:0]  x0, y0, x1, y1;
   logic [15:0] color;
   logic        start, abort, grant;
   wire         busy, done;
   wire  [10:0] pix_cnt;
   wire  [19:0] sram_addr;
   wire  [15:0] sram_dq;
   wire         sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

   int total = 0;
   int bad   = 0;
   logic [31:0] q_addr[$];
   logic [15:0] q_data[$];

   line_raster dut (
      .clk50(clk50), .rst(rst), .x0(x0), .y0(y0), .x1(x1), .y1(y1),
      .color(color), .start(start), .abort(abort), .grant(grant),
      .busy(busy), .done(done), .pix_cnt(pix_cnt),
      .sram_addr(sram_addr), .sram_dq(sram_dq), .sram_ce_n(sram_ce_n),
      .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n),
      .sram_lb_n(sram_lb_n)
   );

   always #10 clk50 = ~clk50;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic push(input logic [31:0] a, input logic [15:0] d);
      q_addr.push_back(a);
      q_data.push_back(d);
   endtask

   // Monitor: every strobed write must match the head of the scoreboard.
   always @(negedge clk50) begin
      if (grant === 1'b1 && sram_we_n === 1'b0) begin
         if (q_addr.size() == 0) begin
            check("unexpected_write_addr", 32'(sram_addr), 32'hFFFF_FFFF);
         end else begin
            check("write_addr", 32'(sram_addr), q_addr.pop_front());
            check("write_data", 32'(sram_dq), 32'(q_data.pop_front()));
            check("write_ce_oe", {30'd0, sram_ce_n, sram_oe_n}, 32'd1);
         end
      end
   end

   // mode: 0 plain, 1 grant stall, 2 start while busy, 3 abort, 4 reset mid-line
   task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                           input logic [15:0] col, input int mode,
                           input int exp_done, input int exp_pix);
      int got;
      @(negedge clk50);
      x0 = 10'(ax0); y0 = 10'(ay0); x1 = 10'(ax1); y1 = 10'(ay1);
      color = col; start = 1'b1;
      @(posedge clk50);
      @(negedge clk50);
      start = 1'b0;
      got = -1;
      for (int e = 1; e <= 60; e++) begin
         @(posedge clk50);
         @(negedge clk50);
         if (mode == 1 && e == 3) grant = 1'b0;
         if (mode == 1 && e == 5) check("stall_busy", 32'(busy), 32'd1);
         if (mode == 1 && e == 8) grant = 1'b1;
         if (mode == 2 && e == 5) begin
            x0 = 10'd100; y0 = 10'd100; x1 = 10'd0; y1 = 10'd0; color = 16'h0BAD;
            start = 1'b1;
         end
         if (mode == 2 && e == 6) start = 1'b0;
         if (mode == 3 && e == 4) abort = 1'b1;
         if (mode == 3 && e == 5) begin
            abort = 1'b0;
            check("abort_busy", 32'(busy), 32'd0);
         end
         if (mode == 4 && e == 5) begin
            #1 rst = 1'b1;
            #1;
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_pix", 32'(pix_cnt), 32'd0);
            check("rst_we_n", 32'(sram_we_n), 32'd1);
            check("rst_addr", 32'(sram_addr), 32'd0);
            check("rst_dq", 32'(sram_dq), 32'd0);
            #3 rst = 1'b0;
         end
         if (done === 1'b1) begin
            got = e;
            break;
         end
      end
      check("done_edge", 32'(got), 32'(exp_done));
      check("pix_cnt", 32'(pix_cnt), 32'(exp_pix));
      check("sb_empty", 32'(q_addr.size()), 32'd0);
      q_addr.delete();
      q_data.delete();
      repeat (2) @(negedge clk50);
   endtask

   initial begin
      rst = 1'b1; grant = 1'b1; start = 1'b0; abort = 1'b0;
      x0 = '0; y0 = '0; x1 = '0; y1 = '0; color = '0;
      repeat (2) @(negedge clk50);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_pix", 32'(pix_cnt), 32'd0);
      check("reset_we_n", 32'(sram_we_n), 32'd1);
      check("reset_addr", 32'(sram_addr), 32'd0);
      rst = 1'b0;

      // horizontal line
      for (int i = 0; i < 4; i++) push(32'(i), 16'hF00F);
      run_line(0, 0, 3, 0, 16'hF00F, 0, 9, 4);

      // diagonal up-left / down
      push(6410, 16'h1234); push(7049, 16'h1234); push(7688, 16'h1234); push(8327, 16'h1234);
      run_line(10, 10, 7, 13, 16'h1234, 0, 9, 4);

      // shallow line with a reverse x step
      push(2, 16'h7777); push(641, 16'h7777); push(640, 16'h7777);
      run_line(2, 0, 0, 1, 16'h7777, 0, 7, 3);

      // right-edge clipping
      push(307198, 16'hABCD); push(307199, 16'hABCD);
      run_line(638, 479, 641, 479, 16'hABCD, 0, 9, 2);

      // grant stall at second PLOT
      for (int i = 0; i < 4; i++) push(32'(i), 16'hF00F);
      run_line(0, 0, 3, 0, 16'hF00F, 1, 14, 4);

      // single-pixel line
      push(3205, 16'h0055);
      run_line(5, 5, 5, 5, 16'h0055, 0, 3, 1);

      // start while busy is ignored
      for (int i = 0; i < 10; i++) push(32'(i), 16'h3C3C);
      run_line(0, 0, 9, 0, 16'h3C3C, 2, 21, 10);

      // abort after second write
      push(0, 16'h5A5A); push(1, 16'h5A5A);
      run_line(0, 0, 9, 0, 16'h5A5A, 3, -1, 2);

      // reset mid-line, then behaves as from power-up
      push(0, 16'h1111); push(1, 16'h1111);
      run_line(0, 0, 9, 0, 16'h1111, 4, -1, 0);
      for (int i = 0; i < 4; i++) push(32'(i), 16'hF00F);
      run_line(0, 0, 3, 0, 16'hF00F, 0, 9, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/line_raster.md
LINE_RASTER -- requirements
Module: line_raster

Interface
REQ-001 SHALL have parameter CW, default 10, coordinate width in bits.
REQ-002 SHALL have parameter H_RES, default 640, framebuffer width in pixels (row pitch).
REQ-003 SHALL have parameter V_RES, default 480, framebuffer height in pixels.
REQ-004 SHALL have parameter AW, default 20, SRAM address width.
REQ-005 SHALL have parameter DW, default 16, pixel data width.
REQ-006 SHALL have parameter BASE_ADDR, default 0, framebuffer base word address.
REQ-007 SHALL have port clk50  in  1  clock; all logic on its rising edge.
REQ-008 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-009 SHALL have ports x0, y0, x1, y1  in  CW each  unsigned line endpoints.
REQ-010 SHALL have port color  in  DW  pixel value written.
REQ-011 SHALL have ports start  in  1  request, and abort  in  1  cancel current line.
REQ-012 SHALL have port grant  in  1  SRAM bus granted to this block.
REQ-013 SHALL have ports busy  out  1  and done  out  1  one-cycle completion pulse.
REQ-014 SHALL have port pix_cnt  out  CW+1  pixels written for the current/last line.
REQ-015 SHALL have ports sram_addr  out  AW, sram_dq  out  DW, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each.

Function
REQ-016 SHALL implement FSM IDLE, SETUP, PLOT, WRITE, DONE; busy=1 in every state except IDLE.
REQ-017 In IDLE with start=1, SHALL latch x0,y0,x1,y1,color, clear pix_cnt, go to SETUP; start outside IDLE SHALL be ignored.
REQ-018 SETUP SHALL compute signed dx=|x1-x0| and dy=-|y1-y0| (CW+1 bits), sx/sy=+1 or -1, err=dx+dy (CW+2 bits), x=x0, y=y0; then go to PLOT.
REQ-019 PLOT with grant=0 SHALL hold state and all registers, sram_we_n=1.
REQ-020 PLOT with grant=1 SHALL register sram_addr=BASE_ADDR+y*H_RES+x (truncated to AW) and sram_dq=color, then go to WRITE.
REQ-021 WRITE SHALL drive sram_we_n=0 for exactly that one cycle if x<H_RES and y<V_RES, and increment pix_cnt; otherwise (clipped) sram_we_n SHALL stay 1 and pix_cnt unchanged.
REQ-022 WRITE exit: if (x,y)==(x1,y1) go to DONE; else e2=2*err (CW+3 bits signed); if e2>=dy then err+=dy, x+=sx; if e2<=dx then err+=dx, y+=sy (both may apply, diagonal step); go to PLOT.
REQ-023 DONE SHALL assert done=1 for one cycle and return to IDLE.
REQ-024 With grant held 1, line of N=max(|dx|,|dy|)+1 pixels: WRITE k at edge 2k after start-accept edge; done high starting edge 2N+1.
REQ-025 abort=1 in any non-IDLE state SHALL go to IDLE next edge, no done pulse; a WRITE in progress SHALL still complete its single cycle.
REQ-026 SRAM outputs SHALL be driven when grant=1 or state=WRITE, else high-Z; when driven: ce_n=0, oe_n=1, ub_n=lb_n=0.
REQ-027 Arbiter SHALL not drop grant in the cycle after a granted PLOT; block SHALL drive bus in WRITE regardless.
REQ-028 sram_we_n SHALL be a registered output, never derived from clk50.
REQ-029 Coordinates outside the framebuffer SHALL be stepped normally (clipped per pixel), never wrapped into the address.

Reset
REQ-030 On rst: state=IDLE, busy=0, done=0, pix_cnt=0, sram_we_n=1, sram_addr=0, sram_dq=0, internal coords/err=0, immediately and independent of clk50.
REQ-031 rst mid-line SHALL abandon the line; first start after release SHALL behave as from power-up.

Verification
REQ-032 (0,0)->(3,0), color 0xF00F, grant=1 -> writes to 0,1,2,3 data 0xF00F; done 9 edges after accept; pix_cnt=4.
REQ-033 (10,10)->(7,13) -> writes 6410, 7049, 7688, 8327 (diagonal steps); pix_cnt=4.
REQ-034 (638,479)->(641,479) -> writes 307198, 307199 only; 4 pixel periods; pix_cnt=2; done pulses.
REQ-035 grant=0 for 5 cycles at the second PLOT of scenario REQ-032 -> bus high-Z, we_n=1, then same address sequence; done 5 edges later.
REQ-036 (5,5)->(5,5) -> single write at 3205, done at edge 3; start pulsed while busy on a long line -> ignored.
REQ-037 abort after second write of (0,0)->(9,0) -> no further writes, no done, busy=0 next edge; rst mid-line -> all outputs at reset values asynchronously.
